// File: rtl/btn_ctrl.sv
// btn_ctrl: per-channel button sync, debounce and press/release/long/repeat pulse generator.
module btn_ctrl #(
  parameter int          N_BTN      = 3,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned DEB_CYC    = 500000,
  parameter int unsigned LONG_CYC   = 25000000,
  parameter int unsigned REP_CYC    = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_p,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] long_p,
  output logic [N_BTN-1:0] repeat_p
);
  localparam int unsigned HMAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [N_BTN-1:0] MASK = ACTIVE_LOW ? '1 : '0;
  typedef enum logic [1:0] {RELEASED, PRESSED, LONG} state_t;
  logic [N_BTN-1:0] r_s1, r_s2;
  logic [DW-1:0]    r_deb [N_BTN];
  logic [HW-1:0]    r_hold [N_BTN];
  state_t           r_st [N_BTN];
  logic [N_BTN-1:0] w_mis, w_acc;
  always_comb begin
    w_mis = '0;
    w_acc = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_mis[i] = r_s2[i] != btn_level[i];
      w_acc[i] = w_mis[i] && (r_deb[i] == DW'(DEB_CYC - 1));
    end
  end
  // Synchronisers hold normalised levels, so the idle (released) value is always 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      btn_level <= '0;
      press_p   <= '0;
      release_p <= '0;
      long_p    <= '0;
      repeat_p  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_deb[i]  <= '0;
        r_hold[i] <= '0;
        r_st[i]   <= RELEASED;
      end
    end else begin
      r_s1      <= btn_in ^ MASK;
      r_s2      <= r_s1;
      press_p   <= '0;
      release_p <= '0;
      long_p    <= '0;
      repeat_p  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_deb[i] <= (w_acc[i] || !w_mis[i]) ? '0 : r_deb[i] + 1'b1;
        if (w_acc[i])
          btn_level[i] <= r_s2[i];
        // An accepted release always takes priority over a terminal count.
        case (r_st[i])
          RELEASED: begin
            if (w_acc[i] && r_s2[i]) begin
              r_st[i]    <= PRESSED;
              press_p[i] <= 1'b1;
              r_hold[i]  <= '0;
            end
          end
          PRESSED: begin
            if (w_acc[i] && !r_s2[i]) begin
              r_st[i]      <= RELEASED;
              release_p[i] <= 1'b1;
              r_hold[i]    <= '0;
            end else if (r_hold[i] == HW'(LONG_CYC - 1)) begin
              r_st[i]   <= LONG;
              long_p[i] <= 1'b1;
              r_hold[i] <= '0;
            end else
              r_hold[i] <= r_hold[i] + 1'b1;
          end
          LONG: begin
            if (w_acc[i] && !r_s2[i]) begin
              r_st[i]      <= RELEASED;
              release_p[i] <= 1'b1;
              r_hold[i]    <= '0;
            end else if (REP_CYC != 0) begin
              if (r_hold[i] == HW'(REP_CYC - 1)) begin
                repeat_p[i] <= 1'b1;
                r_hold[i]   <= '0;
              end else
                r_hold[i] <= r_hold[i] + 1'b1;
            end
          end
          default: begin
            r_st[i]   <= RELEASED;
            r_hold[i] <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: table-driven checks of btn_ctrl with DEB=4, LONG=20, REP=8 plus a REP=0 twin.
module tb_btn_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_in = 3'b111;
  logic [2:0] lvl, pr, rl, lg, rp;
  logic [2:0] lvl0, pr0, rl0, lg0, rp0;
  btn_ctrl #(.N_BTN(3), .ACTIVE_LOW(1'b1), .DEB_CYC(4), .LONG_CYC(20), .REP_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(lvl),
    .press_p(pr), .release_p(rl), .long_p(lg), .repeat_p(rp)
  );
  btn_ctrl #(.N_BTN(3), .ACTIVE_LOW(1'b1), .DEB_CYC(4), .LONG_CYC(20), .REP_CYC(0)) dut_norep (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(lvl0),
    .press_p(pr0), .release_p(rl0), .long_p(lg0), .repeat_p(rp0)
  );
  always #5 clk = ~clk;
  typedef struct {
    string      tag;
    logic [2:0] btn, lvl, pr, rl, lg, rp;
  } vec_t;
  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got lvl/pr/rl/lg/rp=%b expected %b", name, act, exp);
    end
  endtask
  function automatic void add(input int n, input string tag, input logic [2:0] btn,
                              input logic [2:0] l, input logic [2:0] p, input logic [2:0] r,
                              input logic [2:0] g, input logic [2:0] q);
    vec_t v;
    v.tag = tag; v.btn = btn; v.lvl = l; v.pr = p; v.rl = r; v.lg = g; v.rp = q;
    repeat (n) tbl.push_back(v);
  endfunction
  // Channel 2 held for entries 1..h: press at 6, long at 26, repeats every 8, release h+6.
  function automatic void gen_hold(input string tag, input int h, input int t);
    int rel_t;
    rel_t = h + 6;
    for (int k = 1; k <= t; k++)
      add(1, tag, (k <= h) ? 3'b011 : 3'b111,
          (k >= 6 && k < rel_t) ? 3'b100 : 3'b000,
          (k == 6) ? 3'b100 : 3'b000,
          (k == rel_t) ? 3'b100 : 3'b000,
          (k == 26 && k < rel_t) ? 3'b100 : 3'b000,
          (k > 26 && k < rel_t && (k - 26) % 8 == 0) ? 3'b100 : 3'b000);
  endfunction
  task automatic run();
    foreach (tbl[j]) begin
      btn_in = tbl[j].btn;
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tbl[j].tag, j), {lvl, pr, rl, lg, rp},
            {tbl[j].lvl, tbl[j].pr, tbl[j].rl, tbl[j].lg, tbl[j].rp});
      check($sformatf("norep_%s[%0d]", tbl[j].tag, j), {lvl0, pr0, rl0, lg0, rp0},
            {tbl[j].lvl, tbl[j].pr, tbl[j].rl, tbl[j].lg, 3'b000});
    end
    tbl.delete();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", {lvl, pr, rl, lg, rp}, 15'd0);
    check("norep_reset", {lvl0, pr0, rl0, lg0, rp0}, 15'd0);
    rst_n = 1'b1;
    add(5, "ch0_press", 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "ch0_press", 3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    add(4, "ch0_press", 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    add(5, "ch0_rel",   3'b111, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "ch0_rel",   3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
    add(4, "ch0_rel",   3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3, "bounce",    3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "bounce",    3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3, "bounce",    3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(8, "bounce",    3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(4, "deb_min",   3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "deb_min",   3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "deb_min",   3'b111, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000);
    add(3, "deb_min",   3'b111, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "deb_min",   3'b111, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000);
    add(3, "deb_min",   3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(5, "all3",      3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "all3",      3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000);
    add(4, "all3",      3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
    add(5, "all3",      3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
    add(1, "all3",      3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000);
    add(4, "all3",      3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    run();
    gen_hold("long50", 55, 75);
    gen_hold("rel_at_rep", 36, 48);
    gen_hold("rel_at_long", 20, 32);
    run();
    btn_in = 3'b011;
    repeat (30) @(posedge clk);
    #1;
    check("pre_reset_lvl", {lvl, pr, rl, lg, rp}, {3'b100, 12'd0});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {lvl, pr, rl, lg, rp}, 15'd0);
    check("norep_async_reset", {lvl0, pr0, rl0, lg0, rp0}, 15'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    gen_hold("after_reset", 40, 52);
    run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
